// File: rtl/decode_hazard_forward_unit_pkg.sv
// decode_hazard_forward_unit_pkg: forward-select codes, scoreboard entry type, register-width defaults and the register match helper
package decode_hazard_forward_unit_pkg;
  localparam int NB_REG_DEF = 5;
  localparam int NB_REG_MAX = 8;
  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EX_MEM = 2'd1;
  localparam logic [1:0] FWD_MEM_WB = 2'd2;
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic [NB_REG_MAX-1:0] write_reg;
  } sb_entry_t;
  function automatic logic match(input sb_entry_t e, input logic [NB_REG_MAX-1:0] r);
    return e.valid && e.reg_write && (e.write_reg == r) && (r != '0);
  endfunction
endpackage

// File: rtl/decode_hazard_forward_unit_match.sv
// hazard_match_logic: per-operand stall request and decode forward select (sb = EX/MEM/WB scoreboard, r/use_r/decode_use = operand info)
module hazard_match_logic
  import decode_hazard_forward_unit_pkg::*;
#(
  parameter int NB_REG = NB_REG_DEF,
  parameter int NB_SEL = 2,
  parameter int WB_FORWARD = 1
) (
  input  sb_entry_t [2:0]    sb,
  input  logic [NB_REG-1:0]  r,
  input  logic               use_r,
  input  logic               decode_use,
  output logic               stall_req,
  output logic [NB_SEL-1:0]  fwd
);
  logic [NB_REG_MAX-1:0] rx;
  assign rx = NB_REG_MAX'(r);
  always_comb begin
    stall_req = 1'b0;
    fwd = NB_SEL'(FWD_REGFILE);
    for (int k = 2; k >= 0; k--) begin
      if (use_r && match(sb[k], rx)) begin
        stall_req = stall_req || (k == 0 && (sb[k].mem_read || decode_use)) || (k == 1 && sb[k].mem_read && decode_use);
        if (k == 2) fwd = NB_SEL'(WB_FORWARD != 0 ? FWD_MEM_WB : FWD_REGFILE);
        if (k == 1) fwd = NB_SEL'(sb[k].mem_read ? FWD_REGFILE : FWD_EX_MEM);
      end
    end
  end
endmodule

// File: rtl/decode_hazard_forward_unit.sv
// decode_hazard_forward_unit: EX/MEM/WB scoreboard giving decode forward selects forward_A_o/forward_B_o and stall_o from ID operand info; HAZARD_STATS_EN adds saturating stall_count_o
module decode_hazard_forward_unit
  import decode_hazard_forward_unit_pkg::*;
#(
  parameter int NB_REG = NB_REG_DEF,
  parameter int NB_SEL = 2,
  parameter int WB_FORWARD = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [NB_REG-1:0] id_rs,
  input  logic [NB_REG-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_decode_use,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [NB_REG-1:0] id_write_reg,
  output logic [NB_SEL-1:0] forward_A_o,
  output logic [NB_SEL-1:0] forward_B_o,
  output logic              stall_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_count_o
`endif
);
  sb_entry_t [2:0] sb;
  sb_entry_t new_e;
  logic stall_a, stall_b;
  logic [NB_SEL-1:0] fwd_a, fwd_b;
  hazard_match_logic #(.NB_REG(NB_REG), .NB_SEL(NB_SEL), .WB_FORWARD(WB_FORWARD)) u_match_a (
    .sb(sb), .r(id_rs), .use_r(id_use_rs), .decode_use(id_decode_use), .stall_req(stall_a), .fwd(fwd_a)
  );
  hazard_match_logic #(.NB_REG(NB_REG), .NB_SEL(NB_SEL), .WB_FORWARD(WB_FORWARD)) u_match_b (
    .sb(sb), .r(id_rt), .use_r(id_use_rt), .decode_use(id_decode_use), .stall_req(stall_b), .fwd(fwd_b)
  );
  assign stall_o = id_valid && (stall_a || stall_b);
  assign forward_A_o = id_valid ? fwd_a : '0;
  assign forward_B_o = id_valid ? fwd_b : '0;
  assign new_e = (id_valid && !stall_o && !flush) ?
                 sb_entry_t'{valid: 1'b1, reg_write: id_reg_write, mem_read: id_mem_read, write_reg: NB_REG_MAX'(id_write_reg)} : '0;
  always_ff @(posedge clock) begin
    if (reset) sb <= '0;
    else if (enable) sb <= {sb[1:0], new_e};
  end
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) stall_count_o <= '0;
    else if (enable && stall_o && !(&stall_count_o)) stall_count_o <= stall_count_o + 32'd1;
  end
`endif
endmodule

// File: tb/tb_decode_hazard_forward_unit.sv
// tb_decode_hazard_forward_unit: table vectors, directed stall sequences and random traffic against a pipeline-distance model
module tb_decode_hazard_forward_unit;
  logic clock = 1'b0;
  logic reset, enable, flush, id_valid, id_use_rs, id_use_rt, id_decode_use, id_reg_write, id_mem_read;
  logic [4:0] id_rs, id_rt, id_write_reg;
  logic [1:0] fa0, fb0, fa1, fb1;
  logic st0, st1;
`ifdef HAZARD_STATS_EN
  logic [31:0] cnt0, cnt1;
`endif
  int n_tests = 0;
  int n_fail = 0;
  logic h_v[3], h_w[3], h_l[3];
  int h_r[3];
  logic [31:0] m_cnt;
  always #5 clock = ~clock;
  decode_hazard_forward_unit #(.WB_FORWARD(1)) u_wb1 (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_decode_use(id_decode_use), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_write_reg(id_write_reg), .forward_A_o(fa0), .forward_B_o(fb0), .stall_o(st0)
`ifdef HAZARD_STATS_EN
    , .stall_count_o(cnt0)
`endif
  );
  decode_hazard_forward_unit #(.WB_FORWARD(0)) u_wb0 (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_decode_use(id_decode_use), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_write_reg(id_write_reg), .forward_A_o(fa1), .forward_B_o(fb1), .stall_o(st1)
`ifdef HAZARD_STATS_EN
    , .stall_count_o(cnt1)
`endif
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask
  // A producer d stages ahead (1=EX) can be forwarded once it reaches distance 2 (ALU) or 3 (load);
  // a decode consumer needs it now, an EX consumer one cycle later.
  function automatic logic m_stall_op(input int r, input logic u);
    logic s = 1'b0;
    if (!u || r == 0) return 1'b0;
    for (int d = 1; d <= 3; d++)
      if (h_v[d-1] && h_w[d-1] && h_r[d-1] == r && d + (id_decode_use ? 0 : 1) < (h_l[d-1] ? 3 : 2)) s = 1'b1;
    return s;
  endfunction
  function automatic logic m_stall();
    return id_valid && (m_stall_op(int'(id_rs), id_use_rs) || m_stall_op(int'(id_rt), id_use_rt));
  endfunction
  function automatic int m_sel(input int r, input logic u, input int wbf);
    if (!id_valid || !u || r == 0) return 0;
    for (int d = 2; d <= 3; d++)
      if (h_v[d-1] && h_w[d-1] && h_r[d-1] == r) return d == 2 ? (h_l[d-1] ? 0 : 1) : (wbf != 0 ? 2 : 0);
    return 0;
  endfunction
  task automatic model_edge(input logic st);
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        h_v[k] = 1'b0; h_w[k] = 1'b0; h_l[k] = 1'b0; h_r[k] = 0;
      end
      m_cnt = '0;
    end else if (enable) begin
      if (st && m_cnt != 32'hffff_ffff) m_cnt = m_cnt + 32'd1;
      for (int k = 2; k > 0; k--) begin
        h_v[k] = h_v[k-1]; h_w[k] = h_w[k-1]; h_l[k] = h_l[k-1]; h_r[k] = h_r[k-1];
      end
      h_v[0] = id_valid && !st && !flush;
      h_w[0] = id_reg_write;
      h_l[0] = id_mem_read;
      h_r[0] = int'(id_write_reg);
    end
  endtask
  task automatic cycle();
    logic st;
    @(negedge clock);
    st = m_stall();
    if (!reset) begin
      chk("stall", 32'(st0), 32'(st));
      chk("stall_wb0", 32'(st1), 32'(st));
      if (!st) begin
        chk("fwd_a", 32'(fa0), m_sel(int'(id_rs), id_use_rs, 1));
        chk("fwd_b", 32'(fb0), m_sel(int'(id_rt), id_use_rt, 1));
        chk("fwd_a_wb0", 32'(fa1), m_sel(int'(id_rs), id_use_rs, 0));
        chk("fwd_b_wb0", 32'(fb1), m_sel(int'(id_rt), id_use_rt, 0));
      end
`ifdef HAZARD_STATS_EN
      chk("count", cnt0, m_cnt);
      chk("count_wb0", cnt1, m_cnt);
`endif
    end
    @(posedge clock);
    model_edge(st);
    #1;
  endtask
  task automatic drive(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                       input logic du, input logic rw, input logic mr, input int wr);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
    id_decode_use = du; id_reg_write = rw; id_mem_read = mr; id_write_reg = 5'(wr);
  endtask
  task automatic bubble();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask
  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; flush = 1'b0;
    bubble();
    cycle();
    reset = 1'b0;
  endtask
  task automatic want(input string nm, input logic st, input int fa, input int fb);
    #1;
    chk({nm, " stall"}, 32'(st0), 32'(st));
    chk({nm, " fwd_a"}, 32'(fa0), fa);
    chk({nm, " fwd_b"}, 32'(fb0), fb);
  endtask
  typedef struct {
    logic pw, pl; int pr, gap, rs, rt; logic urs, urt, du; logic st; int fa, fb;
  } vec_t;
  vec_t vt[12];
  initial begin
    vt[0]  = '{1'b1, 1'b0, 3, 0, 3, 4, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0};
    vt[1]  = '{1'b1, 1'b0, 3, 1, 3, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0};
    vt[2]  = '{1'b1, 1'b1, 5, 0, 0, 5, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0};
    vt[3]  = '{1'b1, 1'b1, 5, 1, 0, 5, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0};
    vt[4]  = '{1'b1, 1'b1, 5, 2, 0, 5, 1'b1, 1'b1, 1'b1, 1'b0, 0, 2};
    vt[5]  = '{1'b1, 1'b1, 7, 0, 7, 7, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0};
    vt[6]  = '{1'b1, 1'b1, 7, 1, 7, 7, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
    vt[7]  = '{1'b1, 1'b0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
    vt[8]  = '{1'b1, 1'b0, 9, 2, 9, 9, 1'b1, 1'b0, 1'b1, 1'b0, 2, 0};
    vt[9]  = '{1'b0, 1'b0, 3, 0, 3, 4, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
    vt[10] = '{1'b1, 1'b0, 4, 0, 4, 4, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
    vt[11] = '{1'b1, 1'b0, 6, 3, 6, 6, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
    for (int k = 0; k < 3; k++) begin
      h_v[k] = 1'b0; h_w[k] = 1'b0; h_l[k] = 1'b0; h_r[k] = 0;
    end
    m_cnt = '0;
    do_reset();
    repeat (5) begin
      want("idle", 1'b0, 0, 0);
`ifdef HAZARD_STATS_EN
      chk("idle count", cnt0, 32'd0);
`endif
      cycle();
    end
    foreach (vt[i]) begin
      do_reset();
      drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, vt[i].pw, vt[i].pl, vt[i].pr);
      cycle();
      repeat (vt[i].gap) begin bubble(); cycle(); end
      drive(1'b1, vt[i].rs, vt[i].rt, vt[i].urs, vt[i].urt, vt[i].du, 1'b0, 1'b0, 0);
      want($sformatf("vec%0d", i), vt[i].st, vt[i].fa, vt[i].fb);
      chk($sformatf("vec%0d fwd_a_wb0", i), 32'(fa1), vt[i].fa == 2 ? 0 : vt[i].fa);
      chk($sformatf("vec%0d fwd_b_wb0", i), 32'(fb1), vt[i].fb == 2 ? 0 : vt[i].fb);
      cycle();
    end
    do_reset();
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3); cycle();
    drive(1'b1, 3, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    want("alu_beq c0", 1'b1, 0, 0); cycle();
    want("alu_beq c1", 1'b0, 1, 0); cycle();
    do_reset();
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5); cycle();
    drive(1'b1, 0, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    want("lw_beq c0", 1'b1, 0, 0); cycle();
    want("lw_beq c1", 1'b1, 0, 0); cycle();
    want("lw_beq c2", 1'b0, 0, 2);
    chk("lw_beq c2 fwd_b_wb0", 32'(fb1), 0); cycle();
    do_reset();
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7); cycle();
    drive(1'b1, 7, 7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8);
    enable = 1'b0;
    repeat (3) begin want("freeze", 1'b1, 0, 0); cycle(); end
`ifdef HAZARD_STATS_EN
    chk("freeze count", cnt0, 32'd0);
`endif
    enable = 1'b1;
    want("release c0", 1'b1, 0, 0); cycle();
    want("release c1", 1'b0, 0, 0); cycle();
    do_reset();
    flush = 1'b1;
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3); cycle();
    flush = 1'b0;
    drive(1'b1, 3, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    want("flushed producer", 1'b0, 0, 0); cycle();
    do_reset();
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7); cycle();
    flush = 1'b1;
    drive(1'b1, 7, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9);
    want("flush+stall", 1'b1, 0, 0); cycle();
    flush = 1'b0;
    drive(1'b1, 9, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    want("bubble after flush+stall", 1'b0, 0, 0); cycle();
    do_reset();
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3); cycle();
    drive(1'b1, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    want("pre-reset stall", 1'b1, 0, 0);
    reset = 1'b1; cycle(); reset = 1'b0;
    want("reset clears stall", 1'b0, 0, 0); cycle();
    repeat (3000) begin
      reset = ($urandom % 100) == 0;
      enable = ($urandom % 8) != 0;
      flush = ($urandom % 10) == 0;
      drive(($urandom % 4) != 0, int'($urandom % 8), int'($urandom % 8), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), ($urandom % 3) == 0, int'($urandom % 8));
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_hazard_forward_unit.md
Name: decode_hazard_forward_unit

Overview:
- Parametrised successor to the decode-stage forwarding logic. It tracks in-flight destination registers in its own scoreboard shift register: one entry each for EX, MEM and WB.
- Produces per-operand forward selects for decode-stage operand reads (branch compare, jr) and the pipeline stall request.
- Sits beside the ID stage. Fed by the decoder, the pipeline enable from the debug/step unit, and the branch flush.

Parameters:
- NB_REG, 5, register-address width.
- NB_SEL, 2, forward-select width. Encoding: 0 = regfile, 1 = EX/MEM ALU result, 2 = MEM/WB write-back data.
- WB_FORWARD, 1, when 1 the WB entry is a forward source. When 0 the regfile is write-before-read and select 2 is never produced.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  pipeline advance from the debug/step unit. 0 freezes the scoreboard.
- flush  in  1  decode instruction squashed (taken branch/jump).
- id_valid  in  1  decode holds a real instruction.
- id_rs, id_rt  in  NB_REG  source register addresses.
- id_use_rs, id_use_rt  in  1  operand actually read.
- id_decode_use  in  1  operand consumed in ID (beq/bne/jr/jalr).
- id_reg_write  in  1  decode instruction writes a register.
- id_mem_read  in  1  decode instruction is a load.
- id_write_reg  in  NB_REG  destination of the decode instruction.
- forward_A_o, forward_B_o  out  NB_SEL  decode forward selects for rs and rt.
- stall_o  out  1  hold PC and IF/ID, insert bubble into ID/EX.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Scoreboard: 3 entries, index 0 = EX, 1 = MEM, 2 = WB. Each entry holds {valid, reg_write, mem_read, write_reg}.
- Reset: all fields of all entries are 0. Outputs are 0 from the first cycle after reset.
- Update on rising clock when enable=1:
  - entry2 <= entry1; entry1 <= entry0.
  - entry0 <= decode info if id_valid & !stall_o & !flush; otherwise entry0 <= bubble (all 0).
- enable=0: no state change. Outputs are recomputed from the held state.
- reset has priority over enable and flush. reset mid-stall clears the stall next cycle.
- Match(k, r) = entry k valid & reg_write & write_reg == r & r != 0. Register 0 never matches.
- Stall, evaluated per used operand r (rs when id_use_rs, rt when id_use_rt):
  - Match(0, r) & (entry0.mem_read | id_decode_use) raises the stall. This covers load-use and an ALU result needed in ID.
  - Match(1, r) & entry1.mem_read & id_decode_use raises the stall. Load data is not ready until MEM/WB.
  - stall_o is the OR over both operands, gated by id_valid.
  - stall_o is combinational from the registered scoreboard plus the ID inputs.
- Forward select per operand, youngest wins:
  - Match(1, r) & !entry1.mem_read gives 1.
  - Else, when WB_FORWARD=1, Match(2, r) gives 2.
  - Else 0.
  - Match(1) with a load gives 0; the stall covers decode use, and the EX forward unit covers the rest.
- Selects are meaningful only when stall_o=0. They are 0 when id_valid=0 or the operand is unused.
- Load in MEM plus a non-decode consumer: no stall. That case is the EX forward unit's job.
- Stall sequences:
  - Load followed by a dependent beq: 2 stall cycles, then select 2.
  - ALU op followed by a dependent beq: 1 stall cycle, then select 1.
- flush and stall in the same cycle: a bubble enters; flush dominates.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds output stall_count_o, 32 bits.
  - Cleared by reset.
  - Increments on each clock with enable=1 and stall_o=1.
  - Saturates at all-ones.
  - Read by the debug unit.
- Undefined: no port, no counter. Behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - Forward-select constants: FWD_REGFILE=0, FWD_EX_MEM=1, FWD_MEM_WB=2.
  - Scoreboard entry typedef and the NB_REG default.
- One sub-module: hazard_match_logic, instantiated per operand. It takes the scoreboard plus r, use and decode_use, and returns stall_req and the forward select.
- Scoreboard shift and the optional counter stay in the top.

Test Plan:
- Reset, then id_valid=0 for 5 cycles: stall_o=0, forwards 0, stall_count_o=0.
- "add $3" followed by "beq $3,$4" (decode_use=1): 1 cycle stall_o=1, then forward_A_o=1, stall_o=0.
- "lw $5" followed by "beq $0,$5": stall_o=1 for 2 cycles, then forward_B_o=2. With WB_FORWARD=0: forward_B_o=0.
- "lw $7" followed by "add $8,$7,$7" (decode_use=0): 1 stall cycle, then forward_A_o=0 (EX unit forwards).
- Writes to $0 ahead of a dependent beq on $0: no stall, selects 0.
- enable=0 for 3 cycles during a load-use stall: stall_o held at 1 and no counter increment. On release, the stall clears after the expected cycles. Also assert flush with stall: a bubble enters entry0.
